// File: rtl/prg_loader_ctrl_if.sv
// Memory write port between the PRG loader and the RAM/SDRAM write mux.
//   mem_req  : write request, held high until mem_ack is seen
//   mem_addr : 16-bit target address
//   mem_data : 8-bit write data
//   mem_ack  : write accepted this cycle
// master = loader side, slave = memory side.
interface prg_loader_ctrl_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_data,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_data,
    output mem_ack
  );
endinterface

// File: rtl/prg_loader_ctrl.sv
// PRG/cartridge download sequencer for the VIC-20 core.
// Takes the data_io byte stream, optionally strips the 2-byte load-address header, writes the
// payload to sequential addresses over a single req/ack port, then writes the BASIC
// end-of-program pointers into zero page and, if a byte landed at the autostart address,
// pulses force_reset.
// Ports:
//   clk_sys, reset_n        : clock, asynchronous active-low reset
//   dl_active/dl_wr         : download in progress / byte strobe
//   dl_addr/dl_data         : byte offset in the file / byte value
//   use_header              : bytes 0/1 carry the little-endian load address
//   mem                     : write port (master modport)
//   force_reset             : system reset request, RESET_HOLD cycles long
//   busy                    : controller not idle
//   overflow                : sticky, a byte was dropped because a write was pending
module prg_loader_ctrl #(
  parameter logic [15:0] DEFAULT_ADDR   = 16'hA000,
  parameter logic [15:0] AUTORESET_ADDR = 16'hA000,
  parameter int unsigned RESET_HOLD     = 16
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     dl_active,
  input  logic                     dl_wr,
  input  logic [15:0]              dl_addr,
  input  logic [7:0]               dl_data,
  input  logic                     use_header,
  prg_loader_ctrl_if.master        mem,
  output logic                     force_reset,
  output logic                     busy,
  output logic                     overflow
);

  localparam logic [7:0] HoldLast = 8'(RESET_HOLD - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StDrain, StInject, StResetPulse} state_e;

  state_e      state_q, state_d;
  logic        dl_active_q;
  logic        hdr_q, hdr_d;
  logic [15:0] next_addr_q, next_addr_d;
  logic        bytes_seen_q, bytes_seen_d;
  logic        armed_q, armed_d;
  logic        overflow_q, overflow_d;
  logic        mem_req_q, mem_req_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_data_q, mem_data_d;
  logic [2:0]  inj_cnt_q, inj_cnt_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;

  logic        ack_take;
  logic [15:0] addr_use;
  logic [7:0]  zp_addr;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      dl_active_q  <= 1'b0;
      hdr_q        <= 1'b0;
      next_addr_q  <= 16'h0000;
      bytes_seen_q <= 1'b0;
      armed_q      <= 1'b0;
      overflow_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 16'h0000;
      mem_data_q   <= 8'h00;
      inj_cnt_q    <= 3'd0;
      hold_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      dl_active_q  <= dl_active;
      hdr_q        <= hdr_d;
      next_addr_q  <= next_addr_d;
      bytes_seen_q <= bytes_seen_d;
      armed_q      <= armed_d;
      overflow_q   <= overflow_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      inj_cnt_q    <= inj_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    next_addr_d  = next_addr_q;
    bytes_seen_d = bytes_seen_q;
    armed_d      = armed_q;
    overflow_d   = overflow_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    inj_cnt_d    = inj_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    addr_use     = next_addr_q;
    // Zero-page pointer slots: $2D..$32 then $AE/$AF.
    zp_addr      = (inj_cnt_q < 3'd6) ? (8'h2D + {5'b0, inj_cnt_q})
                                      : (8'hA8 + {5'b0, inj_cnt_q});

    // An ack only counts against an outstanding request.
    ack_take = mem_req_q & mem.mem_ack;
    if (ack_take) begin
      mem_req_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (dl_active && !dl_active_q) begin
          state_d      = StLoad;
          hdr_d        = use_header;
          next_addr_d  = DEFAULT_ADDR;
          bytes_seen_d = 1'b0;
          armed_d      = 1'b0;
          overflow_d   = 1'b0;
        end
      end

      StLoad: begin
        if (dl_wr) begin
          if (hdr_q && dl_addr == 16'd0) begin
            next_addr_d[7:0] = dl_data;
          end else if (hdr_q && dl_addr == 16'd1) begin
            next_addr_d[15:8] = dl_data;
          end else if (mem_req_q) begin
            // Previous write still pending: drop this byte, keep the pointer.
            overflow_d = 1'b1;
          end else begin
            addr_use     = (!hdr_q && dl_addr == 16'd0) ? DEFAULT_ADDR : next_addr_q;
            mem_req_d    = 1'b1;
            mem_addr_d   = addr_use;
            mem_data_d   = dl_data;
            next_addr_d  = addr_use + 16'd1;
            bytes_seen_d = 1'b1;
            if (addr_use == AUTORESET_ADDR) begin
              armed_d = 1'b1;
            end
          end
        end
        if (!dl_active) begin
          state_d = StDrain;
        end
      end

      StDrain: begin
        if (!mem_req_q) begin
          inj_cnt_d = 3'd0;
          state_d   = bytes_seen_q ? StInject : StIdle;
        end
      end

      StInject: begin
        if (ack_take) begin
          inj_cnt_d = inj_cnt_q + 3'd1;
          if (inj_cnt_q == 3'd7) begin
            hold_cnt_d = 8'd0;
            state_d    = armed_q ? StResetPulse : StIdle;
          end
        end else if (!mem_req_q) begin
          // Even slots take the low byte of the end pointer, odd slots the high byte.
          mem_req_d  = 1'b1;
          mem_addr_d = {8'h00, zp_addr};
          mem_data_d = inj_cnt_q[0] ? next_addr_q[15:8] : next_addr_q[7:0];
        end
      end

      StResetPulse: begin
        hold_cnt_d = hold_cnt_q + 8'd1;
        if (hold_cnt_q == HoldLast) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign mem.mem_data = mem_data_q;
  assign force_reset  = (state_q == StResetPulse);
  assign busy         = (state_q != StIdle);
  assign overflow     = overflow_q;

endmodule

// File: doc/prg_loader_ctrl.md
Name: prg_loader_ctrl

Overview:
Sequences PRG/cartridge image downloads from the data_io stream into VIC-20 memory through a single req/ack write port.
- Extracts the 2-byte load-address header when enabled and generates sequential target addresses.
- After the download ends, injects the BASIC end-of-program pointers into zero page.
- Issues a timed system reset when a cartridge image was loaded at the autostart address.
- Sits between data_io and the internal-RAM/SDRAM write mux in the top level.

Parameters:
- DEFAULT_ADDR, 16'hA000, load address used when use_header=0.
- AUTORESET_ADDR, 16'hA000, a data byte written here arms the auto-reset.
- RESET_HOLD, 16, force_reset pulse length in clk_sys cycles (range 1..255).

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- dl_active  in  1  PRG/CRT download in progress (index != 0).
- dl_wr  in  1  one-cycle strobe; dl_addr/dl_data valid.
- dl_addr  in  16  byte offset within the image file.
- dl_data  in  8  image byte.
- use_header  in  1  1 = bytes 0/1 are the little-endian load address; sampled at download start.
- mem_req  out  1  write request; held until mem_ack.
- mem_addr  out  16  write address.
- mem_data  out  8  write data.
- mem_ack  in  1  write accepted this cycle.
- force_reset  out  1  system reset request.
- busy  out  1  high in any state except IDLE.
- overflow  out  1  sticky: dl_wr arrived while a write was pending; byte dropped.

Behaviour:
- Reset values: mem_req=0, mem_addr=0, mem_data=0, force_reset=0, busy=0, overflow=0; state IDLE; load/next pointers cleared; armed=0.
- Asynchronous reset mid-operation aborts everything. Outputs return to reset values immediately. No injection occurs.
- States: IDLE, LOAD, DRAIN, INJECT, RESET_PULSE.
- IDLE -> LOAD on the rising edge of dl_active:
  - latch use_header; set next_addr = DEFAULT_ADDR; clear overflow; clear armed.
- LOAD, dl_wr with use_header=1:
  - dl_addr==0 sets next_addr[7:0]; dl_addr==1 sets next_addr[15:8]. No memory write for either.
  - dl_addr>=2 is a data byte.
- LOAD, dl_wr with use_header=0: every byte is a data byte. dl_addr==0 forces next_addr=DEFAULT_ADDR before use.
- Data byte handling:
  - If mem_req=0: next cycle drive mem_req=1, mem_addr=next_addr, mem_data=dl_data; then next_addr <= next_addr+1 (16-bit wrap, FFFF->0000); bytes_seen <= 1.
  - If mem_req=1: drop the byte and set overflow. next_addr does not advance.
  - If mem_addr==AUTORESET_ADDR when the request is issued: set armed.
- mem_req deasserts the cycle after mem_ack is sampled high. mem_ack while mem_req=0 is ignored.
- LOAD -> DRAIN on falling dl_active. DRAIN waits for any pending ack.
- DRAIN exit:
  - bytes_seen=1: go to INJECT.
  - bytes_seen=0 (header-only or empty file): go to IDLE; no injection, no reset.
- INJECT issues 8 sequential req/ack writes, one at a time, with end=next_addr (one past last byte):
  - $002D=end[7:0], $002E=end[15:8], $002F lo, $0030 hi, $0031 lo, $0032 hi, $00AE lo, $00AF hi.
  - Each mem_req rises at least 1 cycle after the previous ack.
  - After the 8th ack: go to RESET_PULSE if armed, else IDLE.
- RESET_PULSE: force_reset=1 for exactly RESET_HOLD cycles, then IDLE with force_reset=0.
- dl_active rising while not IDLE: ignored. dl_wr outside LOAD: ignored, overflow unaffected.
- Write latency: mem_req rises 1 cycle after dl_wr.
- busy=1 from the first LOAD cycle through the last RESET_PULSE cycle.

Test Plan:
1. Header-mode PRG: use_header=1, bytes 01 10 AA BB CC, ack after 2 cycles. Required: writes $1001=AA, $1002=BB, $1003=CC; injection of 04/10 into $2D..$32,$AE,$AF in the specified order; force_reset never asserted; busy drops after the 8th ack.
2. Headerless CRT: use_header=0, 4 bytes. Required: writes $A000..$A003; end pointer=$A004 injected; armed set; force_reset high for exactly 16 cycles, then IDLE.
3. Overflow: hold mem_ack=0 and send two dl_wr 1 cycle apart. Required: first byte written; second dropped; overflow=1; next_addr advanced once. overflow is cleared only at the next download start.
4. Header-only file (2 bytes), then dl_active falls. Required: no mem_req at all; IDLE within 2 cycles; force_reset=0.
5. Wrap: header FF FF with 2 data bytes. Required: writes $FFFF then $0000; injected end=$0001; no auto-reset.
6. Reset mid-INJECT: deassert reset_n after the 3rd injection ack. Required: mem_req, busy and force_reset go low asynchronously; after release the block is IDLE and no further writes occur.
